// File: rtl/inst_encoder.sv
// RV32 instruction encoder and program-memory writer: packs decoded fields and a full immediate into one word.
// Define INST_ENCODER_RANGE_CHECK_EN to flag immediates that do not fit their format or are misaligned.
module inst_encoder #(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int BASE  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    fmt,
    input  logic [6:0]    opcode,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [31:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err
);

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready is combinational (RUN and no start this cycle), in_valid may not depend on in_ready.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

    localparam logic [2:0] FMT_I  = 3'b000;
    localparam logic [2:0] FMT_IL = 3'b001;
    localparam logic [2:0] FMT_S  = 3'b010;
    localparam logic [2:0] FMT_B  = 3'b011;
    localparam logic [2:0] FMT_U  = 3'b100;
    localparam logic [2:0] FMT_J  = 3'b101;
    localparam logic [2:0] FMT_R  = 3'b110;

    localparam logic [AW-1:0] BASE_W  = AW'(BASE);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic [31:0]   word;
    logic          bad_imm;
    logic          enc_err;
    logic          xfer;

`ifdef INST_ENCODER_RANGE_CHECK_EN
    logic fits12, fits13, fits21;
    assign fits12 = (imm[31:11] == {21{imm[11]}});
    assign fits13 = (imm[31:12] == {20{imm[12]}});
    assign fits21 = (imm[31:20] == {12{imm[20]}});
`endif

    always_comb begin
        word    = {25'd0, opcode};
        bad_imm = 1'b0;
        case (fmt)
            FMT_I, FMT_IL: begin
                word[11:7]  = rd;
                word[14:12] = funct3;
                word[19:15] = rs1;
                word[31:20] = imm[11:0];
            end
            FMT_S: begin
                word[11:7]  = imm[4:0];
                word[14:12] = funct3;
                word[19:15] = rs1;
                word[24:20] = rs2;
                word[31:25] = imm[11:5];
            end
            FMT_B: begin
                word[7]     = imm[11];
                word[11:8]  = imm[4:1];
                word[14:12] = funct3;
                word[19:15] = rs1;
                word[24:20] = rs2;
                word[30:25] = imm[10:5];
                word[31]    = imm[12];
            end
            FMT_U: begin
                word[11:7]  = rd;
                word[31:12] = imm[31:12];
            end
            FMT_J: begin
                word[11:7]  = rd;
                word[19:12] = imm[19:12];
                word[20]    = imm[11];
                word[30:21] = imm[10:1];
                word[31]    = imm[20];
            end
            FMT_R: begin
                word[11:7]  = rd;
                word[14:12] = funct3;
                word[19:15] = rs1;
                word[24:20] = rs2;
                word[31:25] = funct7;
            end
            default: ;
        endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
        case (fmt)
            FMT_I, FMT_IL, FMT_S: bad_imm = ~fits12;
            FMT_B:                bad_imm = ~fits13 | imm[0];
            FMT_J:                bad_imm = ~fits21 | imm[0];
            FMT_U:                bad_imm = (imm[11:0] != 12'd0);
            default:              bad_imm = 1'b0;
        endcase
`endif
    end

    assign enc_err = (fmt == 3'b111) | bad_imm;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        in_ready    = (state_q == S_RUN) & ~start;
        xfer        = in_valid & in_ready;
        if (start) begin
            // a same-cycle transfer cannot occur because in_ready is low
            state_d = S_RUN;
            count_d = '0;
            err_d   = 1'b0;
        end else if (xfer) begin
            if (enc_err) begin
                err_d = 1'b1;
            end else begin
                mem_we_d    = 1'b1;
                mem_addr_d  = BASE_W + count_q[AW-1:0];
                mem_wdata_d = word;
                count_d     = count_q + (AW+1)'(1);
                if (count_d == DEPTH_W) begin
                    state_d = S_FULL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign done      = (state_q == S_FULL);
    assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized scoreboard bench for inst_encoder; small AW/DEPTH with a BASE that forces address wrap.
module tb_inst_encoder;
  localparam int AW    = 3;
  localparam int DEPTH = 6;
  localparam int BASE  = 4;
  localparam int W     = AW + 32;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FULL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    fmt = '0;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  int m_state = M_IDLE;
  int m_count = 0;
  int m_err   = 0;

  inst_encoder #(.AW(AW), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .done(done), .err(err)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // reference model: field placement by shifting bit ranges of the inputs
  function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
    logic [31:0] mask;
    mask = (32'd1 << (hi - lo + 1)) - 32'd1;
    return (v >> lo) & mask;
  endfunction

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = 32'(opcode);
    case (fmt)
      3'd0, 3'd1: w = w | (32'(rd) << 7) | (32'(funct3) << 12) | (32'(rs1) << 15) | (bits(imm, 11, 0) << 20);
      3'd2: w = w | (bits(imm, 4, 0) << 7) | (32'(funct3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) | (bits(imm, 11, 5) << 25);
      3'd3: w = w | (bits(imm, 11, 11) << 7) | (bits(imm, 4, 1) << 8) | (32'(funct3) << 12) | (32'(rs1) << 15)
                  | (32'(rs2) << 20) | (bits(imm, 10, 5) << 25) | (bits(imm, 12, 12) << 31);
      3'd4: w = w | (32'(rd) << 7) | (bits(imm, 31, 12) << 12);
      3'd5: w = w | (32'(rd) << 7) | (bits(imm, 19, 12) << 12) | (bits(imm, 11, 11) << 20)
                  | (bits(imm, 10, 1) << 21) | (bits(imm, 20, 20) << 31);
      3'd6: w = w | (32'(rd) << 7) | (32'(funct3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) | (32'(funct7) << 25);
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic bit fits(input int n);
    longint v, lim;
    v   = longint'($signed(imm));
    lim = longint'(1) << (n - 1);
    return (v >= -lim) && (v < lim);
  endfunction

  function automatic bit model_bad();
    bit b;
    b = (fmt == 3'd7);
`ifdef INST_ENCODER_RANGE_CHECK_EN
    case (fmt)
      3'd0, 3'd1, 3'd2: b = !fits(12);
      3'd3: b = !fits(13) || imm[0];
      3'd5: b = !fits(21) || imm[0];
      3'd4: b = (imm % 4096) != 0;
      default: ;
    endcase
`endif
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of stimulus, model update at the edge, status checks after it
  task automatic step(input logic r, input logic s, input logic v);
    bit exp_ready;
    logic [AW-1:0] a;
    @(negedge clk);
    rst_n = r;
    start = s;
    in_valid = v;
    #1;
    exp_ready = (m_state == M_RUN) && !s;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (!r) begin
      m_state = M_IDLE; m_count = 0; m_err = 0;
    end else if (s) begin
      m_state = M_RUN; m_count = 0; m_err = 0;
    end else if (v && exp_ready) begin
      if (model_bad()) begin
        m_err = 1;
      end else begin
        a = AW'((BASE + m_count) % (1 << AW));
        exp_q.push_back({a, model_word()});
        m_count++;
        if (m_count == DEPTH) m_state = M_FULL;
      end
    end
    #1;
    check("count", 32'(count), 32'(m_count));
    check("done", 32'(done), 32'(m_state == M_FULL));
    check("err", 32'(err), 32'(m_err));
    if (!r) begin
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
    end
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic rand_fields();
    logic [31:0] r;
    fmt = 3'($urandom_range(0, 7));
    opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    funct3 = 3'($urandom); funct7 = 7'($urandom);
    r = $urandom;
    case ($urandom_range(0, 3))
      0: imm = r;
      1: imm = {{20{r[11]}}, r[11:0]};
      2: imm = {{11{r[20]}}, r[20:1], 1'b0};
      default: imm = r & 32'hFFFF_F000;
    endcase
  endtask

  // monitor: every write strobe is matched against the head of the expected queue
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (mem_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got addr %0d data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_fail++;
          $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                   mem_addr, mem_wdata, e[W-1:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // directed I, then S and B back to back
    step(1'b1, 1'b1, 1'b0);
    set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("model_I", model_word(), 32'h0050_0093);
    step(1'b1, 1'b0, 1'b1);
    set_fields(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    check("model_S", model_word(), 32'h0020_A423);
    step(1'b1, 1'b0, 1'b1);
    set_fields(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    check("model_B", model_word(), 32'hFE00_0EE3);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);

    // out-of-range I immediate: error with the check build, truncated write otherwise
    set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    set_fields(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);

    // fill a session with in_valid held past the boundary; addresses wrap
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      set_fields(3'd0, 7'h13, 5'($urandom), 5'($urandom), 5'd0, 3'($urandom), 7'd0, 32'($urandom_range(0, 2047)));
      step(1'b1, 1'b0, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // start coincident with in_valid, reset at a transfer edge, reset right after one
    set_fields(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd7);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
